// File: rtl/div_unit.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per clock; fixed latency for all operands.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       DivOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] DivResult,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             zdiv;
  logic             sel_rem;

  logic             accept;
  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] res;

  assign accept = Start &&
                  (state == IDLE ||
                   state == DONE);

  // Operand magnitudes captured on the accepting edge.
  always_comb begin
    sgn   = ~DivOp[0];
    a_mag = SrcA;
    b_mag = SrcB;
    if (sgn && SrcA[WIDTH-1])
      a_mag = -SrcA;
    if (sgn && SrcB[WIDTH-1])
      b_mag = -SrcB;
  end

  // The partial remainder stays below the divisor, so the
  // WIDTH+1 bit trial's MSB is a reliable sign bit.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    take    = ~trial[WIDTH];
  end

  // A zero divisor yields quotient all ones; the remainder
  // path already reconstructs the original dividend.
  always_comb begin
    q_fix = q_neg ? -quo : quo;
    r_fix = r_neg ? -rem : rem;
    res   = q_fix;
    if (sel_rem)
      res = r_fix;
    else if (zdiv)
      res = '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      quo       <= '0;
      rem       <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      zdiv      <= 1'b0;
      sel_rem   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivResult <= '0;
      DivByZero <= 1'b0;
    end else if (accept) begin
      state   <= CALC;
      sel_rem <= DivOp[1];
      quo     <= a_mag;
      dvsr    <= b_mag;
      rem     <= '0;
      cnt     <= '0;
      q_neg   <= sgn &
                 (SrcA[WIDTH-1] ^
                  SrcB[WIDTH-1]);
      r_neg   <= sgn & SrcA[WIDTH-1];
      zdiv    <= (SrcB == '0);
      Busy    <= 1'b1;
      Done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          Done <= 1'b0;
        end
        CALC: begin
          rem <= take ? trial[WIDTH-1:0]
                      : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], take};
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= FIX;
        end
        FIX: begin
          DivResult <= res;
          DivByZero <= zdiv;
          Busy      <= 1'b0;
          Done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases plus
// randomized operations against an arithmetic reference model.
module tb_div_unit;

  localparam int W   = 32;
  localparam int LAT = 34;

  logic         clk;
  logic         reset;
  logic         Start;
  logic [1:0]   DivOp;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         Busy;
  logic         Done;
  logic [W-1:0] DivResult;
  logic         DivByZero;

  int total;
  int bad;

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .DivOp     (DivOp),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Busy      (Busy),
    .Done      (Done),
    .DivResult (DivResult),
    .DivByZero (DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic void model(
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic         z
  );
    longint sa;
    longint sb;
    z  = (b == 0);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (z)
      r = op[1] ? a : '1;
    else if (!op[0])
      r = op[1] ? W'(sa % sb) : W'(sa / sb);
    else
      r = op[1] ? a % b : a / b;
  endfunction

  task automatic do_op(input logic [1:0]   op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input string        tag);
    logic [W-1:0] er;
    logic         ez;
    int           n;
    int           nb;
    bit           got;
    model(op, a, b, er, ez);
    @(negedge clk);
    Start = 1'b1;
    DivOp = op;
    SrcA  = a;
    SrcB  = b;
    @(posedge clk);
    n   = 1;
    nb  = 0;
    got = 0;
    #1;
    if (Busy) nb++;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      Start = 1'b0;
      DivOp = 2'($urandom);
      SrcA  = $urandom;
      SrcB  = $urandom;
      @(posedge clk);
      n++;
      #1;
      if (Done) got = 1;
      else if (Busy) nb++;
    end
    chk({tag, ":lat"}, 64'(n), 64'(LAT));
    chk({tag, ":busy"}, 64'(nb), 64'(LAT - 1));
    chk({tag, ":res"}, 64'(DivResult), 64'(er));
    chk({tag, ":dz"}, 64'(DivByZero), 64'(ez));
    @(posedge clk);
    #1;
    chk({tag, ":pulse"}, 64'(Done), 64'(0));
    chk({tag, ":hold"}, 64'(DivResult), 64'(er));
  endtask

  task automatic b2b_test();
    int n;
    int m;
    @(negedge clk);
    Start = 1'b1;
    DivOp = 2'b01;
    SrcA  = 32'd1000;
    SrcB  = 32'd10;
    @(posedge clk);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 6) begin
        DivOp = 2'b11;
        SrcA  = 32'd1003;
        SrcB  = 32'd7;
      end
      if (Done) break;
    end
    chk("b2b:lat1", 64'(n), 64'(LAT));
    chk("b2b:res1", 64'(DivResult), 64'd100);
    m = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      m++;
      #1;
      if (m == 1) begin
        chk("b2b:w1", 64'(Done), 64'd0);
        chk("b2b:nogap", 64'(Busy), 64'd1);
        Start = 1'b0;
        SrcA  = $urandom;
        SrcB  = $urandom;
      end
      if (Done) break;
    end
    chk("b2b:gap", 64'(m), 64'(LAT));
    chk("b2b:res2", 64'(DivResult), 64'd2);
    chk("b2b:dz2", 64'(DivByZero), 64'd0);
    @(posedge clk);
    #1;
    chk("b2b:w2", 64'(Done), 64'd0);
  endtask

  task automatic reset_test();
    int nd;
    @(negedge clk);
    Start = 1'b1;
    DivOp = 2'b01;
    SrcA  = 32'd5000;
    SrcB  = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst:busy", 64'(Busy), 64'd0);
    chk("rst:done", 64'(Done), 64'd0);
    chk("rst:res", 64'(DivResult), 64'd0);
    chk("rst:dz", 64'(DivByZero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (Done || Busy) nd++;
    end
    chk("rst:quiet", 64'(nd), 64'd0);
    do_op(2'b01, 32'd9, 32'd3, "rst:divu");
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           k;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    Start = 1'b0;
    DivOp = 2'b00;
    SrcA  = '0;
    SrcB  = '0;
    #1;
    chk("init:busy", 64'(Busy), 64'd0);
    chk("init:done", 64'(Done), 64'd0);
    chk("init:res", 64'(DivResult), 64'd0);
    chk("init:dz", 64'(DivByZero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op(2'b01, 32'd100, 32'd7, "divu");
    do_op(2'b11, 32'd100, 32'd7, "remu");
    do_op(2'b00, 32'hFFFFFFF9, 32'd2, "div_neg");
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, "rem_neg");
    do_op(2'b10, 32'd7, 32'hFFFFFFFE, "rem_nb");
    do_op(2'b00, 32'h1234, 32'd0, "div_z");
    do_op(2'b11, 32'h1234, 32'd0, "remu_z");
    do_op(2'b10, 32'hFFFF0000, 32'd0, "rem_zn");
    do_op(2'b00, 32'h80000000, 32'hFFFFFFFF, "ovf_div");
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "ovf_rem");
    do_op(2'b01, 32'hFFFFFFFF, 32'd1, "divu_max");

    b2b_test();
    reset_test();

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      k  = $urandom_range(0, 7);
      case (k)
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: begin
          a = 32'h80000000;
          b = '1;
        end
        3: b = ~W'($urandom_range(0, 15));
        4: a = $urandom_range(0, 1000);
        default: ;
      endcase
      do_op(op, a, b, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
